// File: rtl/strb_meter_pkg.sv
// Shared types and constants for the strobe period meter and its helpers.
// State encoding and match-run saturation limits.
package strb_meter_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_FIRST = 2'd1,
        MEASURE    = 2'd2,
        LOCKED     = 2'd3
    } meter_state_e;

    localparam int                 MATCH_W   = 4;
    localparam logic [MATCH_W-1:0] MATCH_SAT = 4'd15;

endpackage

// File: rtl/strb_edge_det.sv
// Registers a strobe and emits a 1-cycle event on its rising edge.
// Event is combinational from strb_in; a wide pulse yields one event.
module strb_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic strb_in,
    output logic evt
);

    logic strb_d;
    logic strb_q;

    always_comb begin
        strb_d = strb_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            strb_q <= 1'b0;
        end else begin
            strb_q <= strb_d;
        end
    end

    assign evt = strb_in & ~strb_q;

endmodule

// File: rtl/strb_period_meter.sv
// Measures clk cycles between prescaler strobes, declares lock, flags timeout.
// Define PERIOD_TOL_EN to accept +/-1 cycle against the run's first period.
module strb_period_meter
    import strb_meter_pkg::*;
#(
    parameter int CNT_W   = 16,
    parameter int LOCK_N  = 4,
    parameter int TIMEOUT = 1000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               strb_in,
    output logic [CNT_W-1:0]   period,
    output logic               period_vld,
    output logic               locked,
    output logic               timeout,
    output logic [MATCH_W-1:0] match_cnt
);

    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(TIMEOUT - 1);
    localparam logic [MATCH_W-1:0] LOCK_V  = MATCH_W'(LOCK_N);

    meter_state_e       state_d, state_q;
    logic [CNT_W-1:0]   cnt_d, cnt_q;
    logic [CNT_W-1:0]   period_d, period_q;
    logic [CNT_W-1:0]   ref_d, ref_q;
    logic               period_vld_d, period_vld_q;
    logic               locked_d, locked_q;
    logic               timeout_d, timeout_q;
    logic [MATCH_W-1:0] match_cnt_d, match_cnt_q;

    logic               evt;
    logic [CNT_W-1:0]   new_period;
    logic               at_limit;
    logic               is_match;
    logic               first_period;
    logic [MATCH_W-1:0] run_len;

    strb_edge_det u_edge (
        .clk     (clk),
        .rst     (rst),
        .strb_in (strb_in),
        .evt     (evt)
    );

    assign new_period   = cnt_q + 1'b1;
    assign at_limit     = (cnt_q == CNT_MAX);
    assign first_period = (match_cnt_q == '0);

`ifdef PERIOD_TOL_EN
    logic [CNT_W-1:0] diff;
    assign diff     = (new_period >= ref_q) ? (new_period - ref_q) : (ref_q - new_period);
    assign is_match = !first_period && (diff <= CNT_W'(1));
`else
    assign is_match = !first_period && (new_period == ref_q);
`endif

    always_comb begin
        run_len = 4'd1;
        if (is_match) begin
            run_len = (match_cnt_q == MATCH_SAT) ? MATCH_SAT : match_cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        period_d     = period_q;
        ref_d        = ref_q;
        period_vld_d = 1'b0;
        locked_d     = locked_q;
        timeout_d    = timeout_q;
        match_cnt_d  = match_cnt_q;

        if (!en) begin
            state_d     = IDLE;
            cnt_d       = '0;
            locked_d    = 1'b0;
            timeout_d   = 1'b0;
            match_cnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d   = '0;
                    state_d = WAIT_FIRST;
                end
                WAIT_FIRST: begin
                    if (evt) begin
                        cnt_d     = '0;
                        timeout_d = 1'b0;
                        state_d   = MEASURE;
                    end else if (at_limit) begin
                        timeout_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                MEASURE, LOCKED: begin
                    if (evt) begin
                        period_d     = new_period;
                        period_vld_d = 1'b1;
                        cnt_d        = '0;
                        match_cnt_d  = run_len;
`ifdef PERIOD_TOL_EN
                        // Reference stays at the run's first period so slow drift cannot hold lock.
                        if (!is_match) begin
                            ref_d = new_period;
                        end
`else
                        ref_d = new_period;
`endif
                        locked_d = (run_len >= LOCK_V);
                        state_d  = (run_len >= LOCK_V) ? LOCKED : MEASURE;
                    end else if (at_limit) begin
                        timeout_d   = 1'b1;
                        locked_d    = 1'b0;
                        match_cnt_d = '0;
                        state_d     = WAIT_FIRST;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            period_q     <= '0;
            ref_q        <= '0;
            period_vld_q <= 1'b0;
            locked_q     <= 1'b0;
            timeout_q    <= 1'b0;
            match_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            period_q     <= period_d;
            ref_q        <= ref_d;
            period_vld_q <= period_vld_d;
            locked_q     <= locked_d;
            timeout_q    <= timeout_d;
            match_cnt_q  <= match_cnt_d;
        end
    end

    assign period     = period_q;
    assign period_vld = period_vld_q;
    assign locked     = locked_q;
    assign timeout    = timeout_q;
    assign match_cnt  = match_cnt_q;

endmodule

// File: tb/tb_strb_period_meter.sv
// Randomized scoreboard bench for strb_period_meter with a timestamp-based reference model.
module tb_strb_period_meter;

    localparam int CNT_W   = 16;
    localparam int LOCK_N  = 4;
    localparam int TIMEOUT = 1000;

    logic             clk;
    logic             rst;
    logic             en;
    logic             strb_in;
    logic [CNT_W-1:0] period;
    logic             period_vld;
    logic             locked;
    logic             timeout;
    logic [3:0]       match_cnt;

    strb_period_meter #(.CNT_W(CNT_W), .LOCK_N(LOCK_N), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .strb_in    (strb_in),
        .period     (period),
        .period_vld (period_vld),
        .locked     (locked),
        .timeout    (timeout),
        .match_cnt  (match_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit is_tmo;
        int period;
        int match;
        bit locked;
    } exp_t;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    // Reference model: measures time between rising strobes by edge timestamps.
    int k      = 0;
    bit prev_s = 0;
    int mode   = 0;  // 0 off, 1 awaiting first strobe, 2 measuring
    int last_t = 0;
    int ref_p  = 0;
    int run    = 0;
    int m_period = 0;
    bit lck    = 0;
    bit tmo    = 0;

    task automatic check(input string name, input longint act, input longint req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, req);
    endtask

    function automatic bit close_enough(int a, int b);
`ifdef PERIOD_TOL_EN
        return (a - b <= 1) && (b - a <= 1);
`else
        return a == b;
`endif
    endfunction

    task automatic model_edge(input bit r, input bit e, input bit s);
        bit   evt;
        bit   matched;
        int   elapsed;
        exp_t x;
        evt = s && !prev_s;
        k++;
        if (r) begin
            prev_s = 0; mode = 0; run = 0; lck = 0; tmo = 0; m_period = 0; ref_p = 0;
            return;
        end
        prev_s = s;
        if (!e) begin
            mode = 0; lck = 0; tmo = 0; run = 0;
            return;
        end
        if (mode == 0) begin
            mode = 1; last_t = k;
            return;
        end
        elapsed = k - last_t;
        if (mode == 1) begin
            if (evt) begin
                mode = 2; tmo = 0; last_t = k; run = 0;
            end else if (elapsed >= TIMEOUT && !tmo) begin
                tmo = 1;
                x = '{is_tmo: 1, period: m_period, match: 0, locked: 0};
                exp_q.push_back(x);
            end
        end else begin
            if (evt) begin
                matched = (run > 0) && close_enough(elapsed, ref_p);
                run = matched ? ((run + 1 > 15) ? 15 : run + 1) : 1;
`ifdef PERIOD_TOL_EN
                if (!matched) ref_p = elapsed;
`else
                ref_p = elapsed;
`endif
                lck = (run >= LOCK_N);
                m_period = elapsed;
                last_t = k;
                x = '{is_tmo: 0, period: elapsed, match: run, locked: lck};
                exp_q.push_back(x);
            end else if (elapsed >= TIMEOUT) begin
                tmo = 1; lck = 0; run = 0; mode = 1;
                x = '{is_tmo: 1, period: m_period, match: 0, locked: 0};
                exp_q.push_back(x);
            end
        end
    endtask

    // Monitor: pops an expectation whenever the DUT reports a period or a new timeout.
    task automatic handle(input bit saw_tmo);
        exp_t e;
        bit   ok;
        n_total++;
        if (exp_q.size() == 0) begin
            $display("FAIL scoreboard: unexpected %s, period=%0d locked=%0d", saw_tmo ? "timeout" : "period_vld",
                     period, locked);
            return;
        end
        e  = exp_q.pop_front();
        ok = (e.is_tmo == saw_tmo) && (int'(period) == e.period) && (int'(match_cnt) == e.match) &&
             (locked == e.locked) && (timeout == e.is_tmo);
        if (ok) n_pass++;
        else $display("FAIL %s: got period=%0d match=%0d locked=%0d timeout=%0d, expected kind=%s period=%0d match=%0d locked=%0d",
                      saw_tmo ? "timeout_event" : "period_event", period, match_cnt, locked, timeout,
                      e.is_tmo ? "timeout" : "period", e.period, e.match, e.locked);
    endtask

    initial begin
        bit prev_t;
        prev_t = 0;
        forever begin
            @(posedge clk);
            #1;
            if (period_vld) handle(0);
            if (timeout && !prev_t) handle(1);
            prev_t = timeout;
        end
    end

    task automatic step(input bit r, input bit e, input bit s);
        @(negedge clk);
        rst = r; en = e; strb_in = s;
        model_edge(r, e, s);
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input int gap, input int width);
        for (int i = 0; i < gap; i++) step(0, 1, i < width);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_period"}, period, 0);
        check({tag, "_period_vld"}, period_vld, 0);
        check({tag, "_locked"}, locked, 0);
        check({tag, "_timeout"}, timeout, 0);
        check({tag, "_match_cnt"}, match_cnt, 0);
    endtask

    initial begin
        int gap;
        int w;
        rst = 1'b1; en = 1'b0; strb_in = 1'b0;

        repeat (3) step(1, 0, 0);
        step(0, 0, 0);
        sync();
        check_all_zero("reset");

        // Lock at 10
        step(0, 1, 0);
        for (int i = 0; i < 6; i++) pulse(10, 1);
        sync();
        check("lock_locked", locked, 1);
        check("lock_match_cnt", match_cnt, 5);

        // Mismatch at 12, relock, an 11 gap, then back to 10
        for (int i = 0; i < 5; i++) pulse(12, 1);
        pulse(11, 1);
        for (int i = 0; i < 6; i++) pulse(10, 1);

        // Timeout while locked
        repeat (TIMEOUT + 5) step(0, 1, 0);
        sync();
        check("tmo_flag", timeout, 1);
        check("tmo_locked", locked, 0);
        check("tmo_period_held", period, m_period);
        step(0, 1, 1);
        sync();
        check("tmo_cleared", timeout, 0);
        check("tmo_first_no_vld", period_vld, 0);
        repeat (9) step(0, 1, 0);
        pulse(10, 1);
        pulse(10, 1);

        // Wide strobes
        for (int i = 0; i < 6; i++) pulse(8, 3);

        // Boundary: exactly at the threshold, then one past it
        pulse(TIMEOUT, 1);
        pulse(10, 1);
        pulse(TIMEOUT + 1, 1);
        pulse(10, 1);
        pulse(10, 1);

        // Randomized gaps and widths
        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 19))
                0:       gap = $urandom_range(TIMEOUT - 2, TIMEOUT + 2);
                1, 2, 3: gap = $urandom_range(2, 20);
                default: gap = $urandom_range(9, 11);
            endcase
            w = $urandom_range(1, (gap > 3) ? 3 : gap - 1);
            pulse(gap, w);
        end

        // Enable drop while locked
        for (int i = 0; i < 6; i++) pulse(10, 1);
        sync();
        check("pre_drop_locked", locked, 1);
        step(0, 0, 0);
        sync();
        check("drop_locked", locked, 0);
        check("drop_timeout", timeout, 0);
        check("drop_period_held", period, m_period);

        // Reset mid-measurement
        step(0, 1, 0);
        for (int i = 0; i < 3; i++) pulse(10, 1);
        step(1, 1, 0);
        sync();
        check_all_zero("mid_rst");
        step(0, 0, 0);

        repeat (5) step(0, 0, 0);
        sync();
        check("scoreboard_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/strb_period_meter.md
Name: strb_period_meter

Overview:
- Consumer end of the prescaler strobe interface.
- Takes the single-cycle `strb` pulse train from a prescaler and measures the clk-cycle interval between strobes.
- Reports each measured period, declares lock after repeated identical periods, and flags timeout when strobes stop.
- Sits beside the prescaler as its in-system checker and rate monitor.

Parameters:
- CNT_W, 16, width of the interval counter and of the period output.
- LOCK_N, 4, number of consecutive identical periods required to assert locked (legal range 2..15).
- TIMEOUT, 1000, cycles without a strobe before timeout fires; must satisfy 2 ≤ TIMEOUT ≤ 2^CNT_W−1.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset: synchronous, active-high.
- en  in  1  measurement enable.
- strb_in  in  1  strobe from the prescaler; normally a 1-cycle pulse, tolerated if wider.
- period  out  CNT_W  last measured interval in clk cycles.
- period_vld  out  1  1-cycle pulse when period updates.
- locked  out  1  LOCK_N consecutive matching periods seen.
- timeout  out  1  sticky; no strobe for TIMEOUT cycles.
- match_cnt  out  4  current run length of matching periods (debug).

Behaviour:
- Reset values: period=0, period_vld=0, locked=0, timeout=0, match_cnt=0, state=IDLE, interval counter=0, strb_q=0.
- Event definition: event = strb_in & ~strb_q, where strb_q is strb_in registered. A multi-cycle high counts as one event at its first cycle.
- Outputs are registered. Updates from an event sampled at edge t are visible after edge t.
- FSM states:
  - IDLE: en=0. Counter held at 0; locked and timeout cleared; period holds its last value. en=1 → WAIT_FIRST.
  - WAIT_FIRST: counter runs.
    - On event: counter←0, no period output, → MEASURE.
    - If counter reaches TIMEOUT−1 with no event: timeout←1, stay in WAIT_FIRST.
  - MEASURE and LOCKED, on event:
    - period←cnt+1, period_vld←1, counter←0.
    - Example: strobes 10 cycles apart give period=10.
  - MEASURE and LOCKED, match counting:
    - If the new period equals the previous period: match_cnt←min(match_cnt+1,15).
    - Otherwise match_cnt←1.
    - The first period after WAIT_FIRST sets match_cnt=1.
  - MEASURE: match_cnt reaching LOCK_N → locked←1, → LOCKED.
  - LOCKED: a mismatching period → locked←0, match_cnt←1, → MEASURE.
  - MEASURE and LOCKED, timeout: counter reaches TIMEOUT−1 with no event → timeout←1, locked←0, match_cnt←0, → WAIT_FIRST. period is not updated.
- Counter saturates at TIMEOUT−1 and never wraps.
- timeout clears only when a subsequent event is seen, or on en=0 or rst.
- Simultaneous event and timeout threshold in the same cycle: the event wins and no timeout is raised.
- en falling mid-measurement: next cycle → IDLE; any pending event is ignored.
- rst mid-operation: all state returns to reset values on the next edge.

Optional Feature:
- Macro: PERIOD_TOL_EN.
- Defined: a new period matches when |new − reference| ≤ 1.
  - The reference is the first period of the current run and does not track drift.
  - The mismatching period becomes the new reference.
- Undefined: exact equality against the previous period is required.
- Port list is identical in both builds.

Decomposition:
- Shared package strb_meter_pkg:
  - state enum {IDLE, WAIT_FIRST, MEASURE, LOCKED}, 2-bit encoding.
  - MATCH_W=4 constant.
  - MATCH_SAT=15 constant.
- One natural sub-module: strb_edge_det, which registers strb_in and produces the 1-cycle event. It is reusable by other strobe consumers.
- Remaining FSM and counter logic stays in strb_period_meter.

Test Plan:
- Lock: en=1, strobe every 10 cycles for 6 strobes → period_vld on strobes 2–6, each period=10. match_cnt 1,2,3,4 with locked=1 after strobe 5 (4th period); match_cnt=5 after strobe 6.
- Mismatch: locked at 10, then one gap of 12 → period=12, locked=0, match_cnt=1. Four more gaps of 12 → locked=1 (PERIOD_TOL_EN build: a gap of 11 keeps lock).
- Timeout: locked at 10, strobes stop → after 1000 cycles timeout=1, locked=0, period remains 10. Next strobe clears timeout, no period_vld; the following strobe gives period_vld.
- Wide strobe: strb_in high 3 cycles every 8 cycles → exactly one event per pulse, period=8.
- Boundary: a strobe arrives exactly at the cycle the counter hits 999 → no timeout, period=1000.
- Reset/enable: rst asserted mid-MEASURE → all outputs 0 next edge. en dropped while locked → locked=0 next cycle, period held.
